// File: rtl/div_seq_param.sv
// Sequential restoring radix-2 divider, signed or unsigned per operation.
// Optional macro DIV_EARLY_OUT_EN adds a fast path when |a| < |b|.
module div_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signedness,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        FAST
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] b_mag;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic             b_zero;
    logic             overflow_case;
    logic             early;
    logic             accept;
    logic             take_fast;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    assign a_neg_in      = signedness & a[WIDTH-1];
    assign b_neg_in      = signedness & b[WIDTH-1];
    assign a_mag_in      = a_neg_in ? -a : a;
    assign b_mag_in      = b_neg_in ? -b : b;
    assign b_zero        = (b == '0);
    assign overflow_case = signedness && (a == MOST_NEG) && (b == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = !b_zero && (a_mag_in < b_mag_in);
`else
    assign early = 1'b0;
`endif

    // The done cycle is still part of the operation, so a start seen then is dropped.
    assign accept    = (state == IDLE) && start && !done;
    assign take_fast = b_zero || overflow_case || early;

    assign rem_sh  = {rem, dvd[WIDTH-1]};
    assign fits    = (rem_sh >= {1'b0, b_mag});
    assign rem_sub = rem_sh[WIDTH-1:0] - b_mag;

    assign busy = (state != IDLE) || done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = take_fast ? FAST : ITER;
                end
            end
            ITER: begin
                if (count == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            FAST:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // dvd doubles as the quotient shift register; fast results are staged in dvd/rem too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            dvd     <= '0;
            rem     <= '0;
            b_mag   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz      <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            r       <= '0;
            divzero <= 1'b0;
        end else begin
            done <= (state == FIX) || (state == FAST);
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                        dz    <= 1'b0;
                        if (b_zero) begin
                            dvd <= '1;
                            rem <= a;
                            dz  <= 1'b1;
                        end else if (overflow_case) begin
                            dvd <= a;
                            rem <= '0;
                        end else if (early) begin
                            dvd <= '0;
                            rem <= a;
                        end else begin
                            dvd   <= a_mag_in;
                            rem   <= '0;
                            b_mag <= b_mag_in;
                            count <= CW'(WIDTH);
                            q_neg <= signedness & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg <= a_neg_in;
                        end
                    end
                end
                ITER: begin
                    rem   <= fits ? rem_sub : rem_sh[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], fits};
                    count <= count - CW'(1);
                end
                FIX: begin
                    q       <= q_neg ? -dvd : dvd;
                    r       <= r_neg ? -rem : rem;
                    divzero <= dz;
                end
                FAST: begin
                    q       <= dvd;
                    r       <= rem;
                    divzero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param (WIDTH = 32): stimulus pushes expected
// results, a negedge monitor pops and compares whenever done is seen.
module tb_div_seq_param;

    localparam int W = 32;
    // Edge offsets from the start-sampling edge to the done cycle, and busy cycle counts.
    localparam int LAT_FULL  = W + 1;
    localparam int LAT_FAST  = 1;
    localparam int BUSY_FULL = W + 2;
    localparam int BUSY_FAST = 2;

    logic         clk;
    logic         reset;
    logic         start;
    logic         signedness;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         divzero;

    typedef struct {
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           start_cyc;
        int           lat;
        int           busy_n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    div_seq_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signedness (signedness),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .q          (q),
        .r          (r),
        .divzero    (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_done", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("q", 64'(q), 64'(e.eq));
                    checkOutput("r", 64'(r), 64'(e.er));
                    checkOutput("divzero", 64'(divzero), 64'(e.edz));
                    checkOutput("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                    checkOutput("busy_cycles", 64'(busy_cnt), 64'(e.busy_n));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic pushExpected(input logic [W-1:0] eq, input logic [W-1:0] er,
                                input logic edz, input bit fast);
        exp_t e;
        e.eq        = eq;
        e.er        = er;
        e.edz       = edz;
        e.start_cyc = cyc;
        e.lat       = fast ? LAT_FAST : LAT_FULL;
        e.busy_n    = fast ? BUSY_FAST : BUSY_FULL;
        sb.push_back(e);
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a          = $urandom;
            b          = $urandom;
            signedness = ~signedness;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) checkOutput({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic applyStimulus(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sv, input logic [W-1:0] eq, input logic [W-1:0] er,
                                 input logic edz, input bit fast);
        if (done) begin
            @(posedge clk);
            #1;
        end
        a          = av;
        b          = bv;
        signedness = sv;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pushExpected(eq, er, edz, fast);
        waitDone(name);
    endtask

`ifdef DIV_EARLY_OUT_EN
    localparam bit SMALL_FAST = 1'b1;
`else
    localparam bit SMALL_FAST = 1'b0;
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        signedness = 1'b0;
        a          = '0;
        b          = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_q", 64'(q), 64'd0);
        checkOutput("reset_r", 64'(r), 64'd0);
        checkOutput("reset_divzero", 64'(divzero), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
        applyStimulus("sm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
        applyStimulus("sm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus("u_div0", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b1);
        applyStimulus("s_div0", 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b1);
        applyStimulus("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        applyStimulus("u_minneg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, SMALL_FAST);
        applyStimulus("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        applyStimulus("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0);
        applyStimulus("u5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, SMALL_FAST);
        applyStimulus("sm5_9", 32'hFFFF_FFFB, 32'd9, 1'b1, 32'd0, 32'hFFFF_FFFB, 1'b0, SMALL_FAST);
        applyStimulus("s7_2", 32'd7, 32'd2, 1'b1, 32'd3, 32'd1, 1'b0, 1'b0);

        // Abort an operation mid-iteration with reset.
        a          = 32'd100;
        b          = 32'd7;
        signedness = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_q", 64'(q), 64'd0);
        checkOutput("abort_r", 64'(r), 64'd0);
        checkOutput("abort_divzero", 64'(divzero), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);

        // Start held high: the done-cycle request is dropped, the next IDLE cycle is taken.
        @(posedge clk);
        #1;
        a          = 32'd20;
        b          = 32'd3;
        signedness = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        pushExpected(32'd6, 32'd2, 1'b0, 1'b0);
        waitDone("held1");
        a          = 32'd45;
        b          = 32'd6;
        signedness = 1'b0;
        @(negedge clk);
        a = 32'd50;
        b = 32'd7;
        @(posedge clk);
        #1;
        pushExpected(32'd7, 32'd1, 1'b0, 1'b0);
        waitDone("held2");
        start = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
